// File: rtl/servile_mem_sched.sv
// Round-robin scheduler sharing one Wishbone memory port between ibus, dbus and an external master.
// One transfer at a time, with a per-transfer timeout that terminates a stalled access.
module servile_mem_sched #(
  parameter int unsigned timeout = 255,
  parameter bit          sim     = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_ibus_adr,
  input  logic        i_wb_ibus_stb,
  output logic [31:0] o_wb_ibus_rdt,
  output logic        o_wb_ibus_ack,
  input  logic [31:0] i_wb_dbus_adr,
  input  logic [31:0] i_wb_dbus_dat,
  input  logic [3:0]  i_wb_dbus_sel,
  input  logic        i_wb_dbus_we,
  input  logic        i_wb_dbus_stb,
  output logic [31:0] o_wb_dbus_rdt,
  output logic        o_wb_dbus_ack,
  input  logic [31:0] i_wb_ext_adr,
  input  logic [31:0] i_wb_ext_dat,
  input  logic [3:0]  i_wb_ext_sel,
  input  logic        i_wb_ext_we,
  input  logic        i_wb_ext_stb,
  output logic [31:0] o_wb_ext_rdt,
  output logic        o_wb_ext_ack,
  output logic        o_wb_ext_err,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_stb,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_timeout
);

  localparam int unsigned cnt_w = 16;
  localparam logic [cnt_w-1:0] term = cnt_w'(timeout - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       gnt;
  logic [1:0]       last;
  logic [1:0]       pick;
  logic [cnt_w-1:0] cnt;
  logic             any_stb;
  logic             m_stb;
  logic             mem_ack;
  logic             to_hit;
  logic             done;

  assign any_stb = i_wb_ibus_stb | i_wb_dbus_stb | i_wb_ext_stb;

  // Round-robin: search starts at the master after the last one granted.
  always_comb begin
    pick = 2'd0;
    case (last)
      2'd0:    pick = i_wb_dbus_stb ? 2'd1 : (i_wb_ext_stb  ? 2'd2 : 2'd0);
      2'd1:    pick = i_wb_ext_stb  ? 2'd2 : (i_wb_ibus_stb ? 2'd0 : 2'd1);
      default: pick = i_wb_ibus_stb ? 2'd0 : (i_wb_dbus_stb ? 2'd1 : 2'd2);
    endcase
  end

  // Request mux from the granted master onto the memory port.
  always_comb begin
    m_stb        = 1'b0;
    o_wb_mem_adr = 32'h0;
    o_wb_mem_dat = 32'h0;
    o_wb_mem_sel = 4'h0;
    o_wb_mem_we  = 1'b0;
    case (gnt)
      2'd0: begin
        m_stb        = i_wb_ibus_stb;
        o_wb_mem_adr = i_wb_ibus_adr;
        o_wb_mem_sel = 4'hF;
      end
      2'd1: begin
        m_stb        = i_wb_dbus_stb;
        o_wb_mem_adr = i_wb_dbus_adr;
        o_wb_mem_dat = i_wb_dbus_dat;
        o_wb_mem_sel = i_wb_dbus_sel;
        o_wb_mem_we  = i_wb_dbus_we;
      end
      default: begin
        m_stb        = i_wb_ext_stb;
        o_wb_mem_adr = i_wb_ext_adr;
        o_wb_mem_dat = i_wb_ext_dat;
        o_wb_mem_sel = i_wb_ext_sel;
        o_wb_mem_we  = i_wb_ext_we;
      end
    endcase
  end

  assign o_wb_mem_stb = m_stb & (state == BUSY);
  assign mem_ack      = o_wb_mem_stb & i_wb_mem_ack;
  // A real ack on the terminal count wins over the timeout.
  assign to_hit       = o_wb_mem_stb & ~i_wb_mem_ack & (cnt == term);
  assign done         = mem_ack | to_hit;

  assign o_wb_ibus_ack = done & (gnt == 2'd0);
  assign o_wb_dbus_ack = done & (gnt == 2'd1);
  assign o_wb_ext_ack  = done & (gnt == 2'd2);
  assign o_wb_ext_err  = to_hit & (gnt == 2'd2);
  assign o_timeout     = to_hit;

  assign o_wb_ibus_rdt = (to_hit && gnt == 2'd0) ? 32'h0 : i_wb_mem_rdt;
  assign o_wb_dbus_rdt = (to_hit && gnt == 2'd1) ? 32'h0 : i_wb_mem_rdt;
  assign o_wb_ext_rdt  = (to_hit && gnt == 2'd2) ? 32'h0 : i_wb_mem_rdt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      gnt   <= 2'd0;
      last  <= 2'd2;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_stb) begin
            gnt   <= pick;
            last  <= pick;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        default: begin
          // Dropped strobe, ack or timeout all end the transfer.
          if (!m_stb || done) state <= IDLE;
          else                cnt   <= cnt + cnt_w'(1);
        end
      endcase
    end
  end

  generate
    if (sim) begin : g_sim
      always_ff @(posedge i_clk) begin
        if (!i_rst && to_hit) $info("servile_mem_sched: transfer to master %0d timed out", gnt);
      end
    end
  endgenerate

endmodule

// File: tb/tb_servile_mem_sched.sv
// Cycle-by-cycle directed vectors for servile_mem_sched, built with a 4-cycle timeout.
module tb_servile_mem_sched;

  localparam int unsigned to_cyc = 4;
  localparam logic [31:0] iadr = 32'h0000_1000;
  localparam logic [31:0] dadr = 32'h0000_0100;
  localparam logic [31:0] ddat = 32'hDEAD_BEEF;
  localparam logic [3:0]  dsel = 4'h3;
  localparam logic [31:0] eadr = 32'h0000_2000;
  localparam logic [31:0] edat = 32'h1234_5678;
  localparam logic [3:0]  esel = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibus_adr, ibus_rdt;
  logic        ibus_stb, ibus_ack;
  logic [31:0] dbus_adr, dbus_dat, dbus_rdt;
  logic [3:0]  dbus_sel;
  logic        dbus_we, dbus_stb, dbus_ack;
  logic [31:0] ext_adr, ext_dat, ext_rdt;
  logic [3:0]  ext_sel;
  logic        ext_we, ext_stb, ext_ack, ext_err;
  logic [31:0] mem_adr, mem_dat, mem_rdt;
  logic [3:0]  mem_sel;
  logic        mem_we, mem_stb, mem_ack;
  logic        tmo;

  servile_mem_sched #(.timeout(to_cyc), .sim(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_stb(ibus_stb),
    .o_wb_ibus_rdt(ibus_rdt), .o_wb_ibus_ack(ibus_ack),
    .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat), .i_wb_dbus_sel(dbus_sel),
    .i_wb_dbus_we(dbus_we), .i_wb_dbus_stb(dbus_stb),
    .o_wb_dbus_rdt(dbus_rdt), .o_wb_dbus_ack(dbus_ack),
    .i_wb_ext_adr(ext_adr), .i_wb_ext_dat(ext_dat), .i_wb_ext_sel(ext_sel),
    .i_wb_ext_we(ext_we), .i_wb_ext_stb(ext_stb),
    .o_wb_ext_rdt(ext_rdt), .o_wb_ext_ack(ext_ack), .o_wb_ext_err(ext_err),
    .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
    .o_wb_mem_we(mem_we), .o_wb_mem_stb(mem_stb),
    .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack),
    .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  // stb / eack bit order is {ext, dbus, ibus}; g is the master expected on the memory port.
  typedef struct {
    logic       rst;
    logic [2:0] stb;
    logic       ack;
    logic [1:0] g;
    logic       estb;
    logic [2:0] eack;
    logic       err;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   idx    = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] s, input logic a, input logic [1:0] g,
                              input logic es, input logic [2:0] ea, input logic er, input logic t);
    vec_t v;
    v.rst = r; v.stb = s; v.ack = a; v.g = g; v.estb = es; v.eack = ea; v.err = er; v.tmo = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at vector %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [31:0] rval;
    logic [31:0] xadr, xdat;
    logic [3:0]  xsel;
    logic        xwe;
    logic [31:0] xrdt;

    // Round robin with all three requesting: ibus, dbus, ext, ibus
    vecs.push_back(mk(0, 3'b111, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2'd0, 1, 3'b001, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2'd1, 1, 3'b010, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2'd2, 1, 3'b100, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2'd0, 1, 3'b001, 0, 0));
    // ext read, memory silent: timeout in the 4th BUSY cycle
    vecs.push_back(mk(0, 3'b100, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b100, 1, 1));
    vecs.push_back(mk(0, 3'b000, 0, 2'd0, 0, 3'b000, 0, 0));
    // ext read, ack on the terminal count: normal completion
    vecs.push_back(mk(0, 3'b100, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 1, 2'd2, 1, 3'b100, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 2'd0, 0, 3'b000, 0, 0));
    // ibus granted, reset mid-transfer, late ack ignored, ibus first again
    vecs.push_back(mk(0, 3'b001, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b001, 0, 2'd0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'b001, 0, 2'd0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 2'd0, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 1, 2'd0, 1, 3'b001, 0, 0));
    // dbus granted then drops stb; pending ext granted next
    vecs.push_back(mk(0, 3'b110, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b110, 0, 2'd1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b110, 0, 2'd1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd0, 0, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 0, 2'd2, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b100, 1, 2'd2, 1, 3'b100, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 2'd0, 0, 3'b000, 0, 0));

    rst = 1'b1;
    ibus_adr = iadr; ibus_stb = 1'b0;
    dbus_adr = dadr; dbus_dat = ddat; dbus_sel = dsel; dbus_we = 1'b1; dbus_stb = 1'b0;
    ext_adr = eadr; ext_dat = edat; ext_sel = esel; ext_we = 1'b0; ext_stb = 1'b0;
    mem_rdt = 32'h0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: IDLE, nothing driven or acked
    @(negedge clk);
    #1;
    chk("reset_mem_stb", 32'(mem_stb), 32'h0);
    chk("reset_acks", 32'({ext_ack, dbus_ack, ibus_ack}), 32'h0);
    chk("reset_err_tmo", 32'({ext_err, tmo}), 32'h0);
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      idx  = i;
      rval = 32'hA500_0000 + 32'(i);
      @(negedge clk);
      rst      = vecs[i].rst;
      ibus_stb = vecs[i].stb[0];
      dbus_stb = vecs[i].stb[1];
      ext_stb  = vecs[i].stb[2];
      mem_ack  = vecs[i].ack;
      mem_rdt  = rval;
      #1;
      chk("mem_stb", 32'(mem_stb), 32'(vecs[i].estb));
      chk("acks", 32'({ext_ack, dbus_ack, ibus_ack}), 32'(vecs[i].eack));
      chk("ext_err", 32'(ext_err), 32'(vecs[i].err));
      chk("timeout", 32'(tmo), 32'(vecs[i].tmo));
      if (vecs[i].estb) begin
        case (vecs[i].g)
          2'd0:    begin xadr = iadr; xdat = 32'h0; xsel = 4'hF; xwe = 1'b0; end
          2'd1:    begin xadr = dadr; xdat = ddat;  xsel = dsel; xwe = 1'b1; end
          default: begin xadr = eadr; xdat = edat;  xsel = esel; xwe = 1'b0; end
        endcase
        chk("mem_adr", mem_adr, xadr);
        chk("mem_dat", mem_dat, xdat);
        chk("mem_sel", 32'(mem_sel), 32'(xsel));
        chk("mem_we", 32'(mem_we), 32'(xwe));
      end
      xrdt = vecs[i].tmo ? 32'h0 : rval;
      if (vecs[i].eack[0]) chk("ibus_rdt", ibus_rdt, xrdt);
      if (vecs[i].eack[1]) chk("dbus_rdt", dbus_rdt, xrdt);
      if (vecs[i].eack[2]) chk("ext_rdt", ext_rdt, xrdt);
      @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
